ecc_mem_responder: RTL
======================

# ecc_mem_responder

Synthesizable responder for the picorv32 native memory interface. Backs a word-addressed RAM whose every 32-bit word is stored as a 39-bit SECDED Hamming codeword. Corrects single-bit errors, flags double-bit errors, maps the 0x1000_0000 console port, and accepts a transient error-injection mask for fault campaigns. It sits on the memory side of the core: the core initiates, this block responds.

## Interface
- MEM_WORDS, 65536: RAM depth in 32-bit words; the byte range is 0 .. 4*MEM_WORDS-1.
- CONSOLE_ADDR, 32'h1000_0000: write-only console byte port.
- SCRUB, 1: write back the corrected codeword after a corrected read.

Ports (reset is synchronous and active-high; one clock):
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- mem_valid  in  1  request from the core.
- mem_instr  in  1  instruction fetch; informational only, no effect on behaviour.
- mem_addr  in  32  byte address; bits [1:0] are ignored.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte strobes; 0 means read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data; valid while mem_ready=1.
- err_inj  in  39  XOR mask applied to the RAM read codeword before decode; not written back by injection itself.
- console_valid  out  1  one-cycle pulse on a console write.
- console_data  out  8  mem_wdata[7:0] of the console write.
- ecc_corrected  out  1  one-cycle pulse: single-bit error corrected.
- ecc_uncorrectable  out  1  one-cycle pulse: double-bit error detected.
- corr_count  out  16  saturating count of corrected events.
- uncorr_count  out  16  saturating count of uncorrectable events.

## Operation
- Codeword layout: 32 data bits, 6 Hamming check bits at positions 1, 2, 4, 8, 16, 32, and 1 overall parity bit (bit 38).
- Decode outcomes:
  - syndrome=0, parity ok: clean.
  - syndrome!=0, parity bad: single-bit error; flip the bit at the syndrome position; corrected.
  - syndrome=0, parity bad: parity bit flipped; data is good; corrected.
  - syndrome!=0, parity ok: uncorrectable. Return the raw data bits and pulse ecc_uncorrectable.
- FSM states: IDLE, RD, DEC, RMW_RD, RMW_WR, SCRUB_WR, RESP.
- IDLE: capture the request when mem_valid=1 and mem_ready=0.
  - Console write (address = CONSOLE_ADDR, wstrb != 0): pulse console_valid, then RESP. No RAM access.
  - Out of range: reads return 32'h0, writes are dropped, then RESP.
  - wstrb=4'hF: encode and write the RAM in the same cycle, then RESP.
  - wstrb=0: RD.
  - Partial strobes: RMW_RD.
- RD: the RAM read is in flight; next state is DEC.
- DEC: decode, drive mem_rdata, pulse mem_ready.
  - Next state is SCRUB_WR if corrected and SCRUB=1; otherwise IDLE.
- RMW_RD: RAM read is in flight. RMW_WR: decode, merge strobed bytes, re-encode, write.
  - If the word is uncorrectable, the write is aborted and ecc_uncorrectable pulses.
  - mem_ready pulses in both cases.
- SCRUB_WR: write the corrected codeword to the same index; mem_ready stays 0.
- RESP: pulse mem_ready for one cycle, then IDLE.
- Counters increment once per event and saturate at 16'hFFFF.
- A partial write that hits a correctable word counts as corrected.

## Timing
- RAM is synchronous: one-cycle read latency, and one read or one write per cycle.
- Latency from the mem_valid capture edge (cycle 0):
  - Full-word write, console write, or out-of-range access: mem_ready in cycle 1.
  - Read: mem_ready in cycle 2.
  - Partial write: mem_ready in cycle 2.
  - Scrub adds one busy cycle after mem_ready; the next request is captured no earlier than cycle 4.
- Handshake: the core holds mem_valid until mem_ready. The block samples the request only in IDLE. mem_ready is never high for two consecutive cycles.
- err_inj is sampled in the DEC / RMW_WR cycle, combinationally on the RAM output.
- Reset values:
  - mem_ready, console_valid, ecc_corrected, ecc_uncorrectable, corr_count, uncorr_count: 0.
  - mem_rdata, console_data: 32'h0 / 8'h0.
  - FSM: IDLE.
- RAM contents are not reset.
- Reset mid-operation: return to IDLE on the next edge. An in-flight RMW or scrub write is not performed unless its write cycle has already passed.

## Structure
- Package ecc_pkg holds:
  - CW_W=39 and the check-bit position constants.
  - The state enum.
  - Pure functions secded_encode(data32) and secded_syndrome(cw39).
- Sub-module secded39_codec:
  - Combinational encoder and decoder.
  - Outputs: corrected data, corrected codeword, single/double flags.
- The FSM, counters and RAM stay in the top module.

## Test plan
- Full write then read: write 32'hDEADBEEF to 0x100, then read 0x100 → mem_ready at cycle 2, mem_rdata=32'hDEADBEEF, no ECC pulses.
- Single-bit injection: err_inj=39'h1 during the read of 0x100 → rdata=32'hDEADBEEF, ecc_corrected=1, corr_count=1. A scrub write follows. A re-read with err_inj=0 is clean.
- Double-bit injection: err_inj=39'h3 → ecc_uncorrectable=1, uncorr_count=1, mem_ready still pulses.
- Partial write: wstrb=4'b0010 with wdata=32'h0000_5500 to 0x100 → a later read returns 32'hDEAD55EF.
- Partial write with double error: err_inj=39'h3 during RMW → the word is unchanged; a later clean read returns 32'hDEADBEEF.
- Console write of 32'h41 to CONSOLE_ADDR → console_valid pulse with console_data=8'h41, mem_ready in cycle 1.
- Reset asserted in cycle 1 of a read → mem_ready stays 0 and the FSM is in IDLE.

Source files
------------

// File: rtl/ecc_mem_responder_pkg.sv
// Shared SECDED(39,32) definitions: codeword geometry, responder FSM states and
// the pure encode/syndrome helpers used by the codec.
package ecc_pkg;

   localparam int CW_W    = 39;
   localparam int DATA_W  = 32;
   localparam int SYN_W   = 6;
   localparam int PAR_BIT = 38;

   // Hamming positions are 1-based: codeword bit i holds position i+1.
   localparam int CHK_POS0 = 1;
   localparam int CHK_POS1 = 2;
   localparam int CHK_POS2 = 4;
   localparam int CHK_POS3 = 8;
   localparam int CHK_POS4 = 16;
   localparam int CHK_POS5 = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_DEC,
      ST_RMW_RD,
      ST_RMW_WR,
      ST_SCRUB_WR,
      ST_RESP
   } state_t;

   function automatic logic is_check_pos(input int pos);
      return (pos & (pos - 1)) == 0;
   endfunction

   function automatic logic [SYN_W-1:0] secded_syndrome(input logic [CW_W-1:0] cw);
      logic [SYN_W-1:0] syn;
      syn = '0;
      for (int i = 0; i < CW_W - 1; i++) begin
         if (cw[6'(i)]) syn = syn ^ SYN_W'(i + 1);
      end
      return syn;
   endfunction

   function automatic logic [CW_W-1:0] secded_place(input logic [DATA_W-1:0] data);
      logic [CW_W-1:0] cw;
      int j;
      cw = '0;
      j  = 0;
      for (int pos = 1; pos < CW_W; pos++) begin
         if (!is_check_pos(pos)) begin
            cw[6'(pos - 1)] = data[5'(j)];
            j++;
         end
      end
      return cw;
   endfunction

   function automatic logic [DATA_W-1:0] secded_extract(input logic [CW_W-1:0] cw);
      logic [DATA_W-1:0] data;
      int j;
      data = '0;
      j    = 0;
      for (int pos = 1; pos < CW_W; pos++) begin
         if (!is_check_pos(pos)) begin
            data[5'(j)] = cw[6'(pos - 1)];
            j++;
         end
      end
      return data;
   endfunction

   // Check bit k sits at position 2^k, so setting it to syndrome bit k zeroes the syndrome.
   function automatic logic [CW_W-1:0] secded_encode(input logic [DATA_W-1:0] data);
      logic [CW_W-1:0]  cw;
      logic [SYN_W-1:0] syn;
      cw  = secded_place(data);
      syn = secded_syndrome(cw);
      for (int k = 0; k < SYN_W; k++) begin
         cw[6'((1 << k) - 1)] = syn[3'(k)];
      end
      cw[PAR_BIT] = ^cw[CW_W-2:0];
      return cw;
   endfunction

endpackage

// File: rtl/ecc_mem_responder_codec.sv
// Combinational SECDED(39,32) encoder and single-correct / double-detect decoder.
module secded39_codec
   import ecc_pkg::*;
(
   input  logic [DATA_W-1:0] enc_data,
   output logic [CW_W-1:0]   enc_cw,
   input  logic [CW_W-1:0]   dec_cw_in,
   output logic [DATA_W-1:0] dec_data,
   output logic [CW_W-1:0]   dec_cw,
   output logic              single_err,
   output logic              double_err
);

   logic [SYN_W-1:0] syn;
   logic             par_bad;
   logic [CW_W-1:0]  fixed;

   assign enc_cw = secded_encode(enc_data);

   // A syndrome beyond the last codeword position cannot come from one flip.
   always_comb begin
      syn        = secded_syndrome(dec_cw_in);
      par_bad    = ^dec_cw_in;
      fixed      = dec_cw_in;
      single_err = 1'b0;
      double_err = 1'b0;
      if (par_bad) begin
         if (syn == '0) begin
            fixed[PAR_BIT] = ~dec_cw_in[PAR_BIT];
            single_err     = 1'b1;
         end else if (syn <= SYN_W'(CW_W - 1)) begin
            fixed[syn - 6'd1] = ~dec_cw_in[syn - 6'd1];
            single_err        = 1'b1;
         end else begin
            double_err = 1'b1;
         end
      end else if (syn != '0) begin
         double_err = 1'b1;
      end
   end

   assign dec_cw   = fixed;
   assign dec_data = secded_extract(fixed);

endmodule

// File: rtl/ecc_mem_responder.sv
// picorv32 native-bus memory responder backed by a SECDED-protected word RAM,
// with a console byte port, read scrubbing and error-injection hooks.
module ecc_mem_responder
   import ecc_pkg::*;
#(
   parameter int          MEM_WORDS    = 65536,
   parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
   parameter bit          SCRUB        = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   input  logic [38:0] err_inj,
   output logic        console_valid,
   output logic [7:0]  console_data,
   output logic        ecc_corrected,
   output logic        ecc_uncorrectable,
   output logic [15:0] corr_count,
   output logic [15:0] uncorr_count
);

   localparam int IDX_W = $clog2(MEM_WORDS);

   state_t state, next_state;

   logic [CW_W-1:0]  ram [MEM_WORDS];
   logic [CW_W-1:0]  ram_q;
   logic             ram_re, ram_we;
   logic [IDX_W-1:0] ram_widx;
   logic [CW_W-1:0]  ram_wcw;

   logic [IDX_W-1:0] req_idx;
   logic [31:0]      req_wdata;
   logic [3:0]       req_wstrb;
   logic [CW_W-1:0]  scrub_cw;

   logic             resp_state, capture, is_console, in_range;
   logic [IDX_W-1:0] cur_idx;
   logic [31:0]      merged, enc_data, dec_data;
   logic [CW_W-1:0]  enc_cw, dec_cw;
   logic             single_err, double_err;
   logic             unused_bits;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign unused_bits = ^{mem_instr, mem_addr[1:0]};

   assign resp_state = (state == ST_DEC) || (state == ST_RMW_WR) || (state == ST_RESP);
   assign capture    = (state == ST_IDLE) && mem_valid && !resp_state;
   assign is_console = (mem_addr[31:2] == CONSOLE_ADDR[31:2]) && (mem_wstrb != 4'h0);
   assign in_range   = mem_addr[31:2] < 30'(MEM_WORDS);
   assign cur_idx    = mem_addr[IDX_W+1:2];

   secded39_codec u_codec (
      .enc_data   (enc_data),
      .enc_cw     (enc_cw),
      .dec_cw_in  (ram_q ^ err_inj),
      .dec_data   (dec_data),
      .dec_cw     (dec_cw),
      .single_err (single_err),
      .double_err (double_err)
   );

   always_comb begin
      merged = dec_data;
      for (int b = 0; b < 4; b++) begin
         if (req_wstrb[b]) merged[8*b +: 8] = req_wdata[8*b +: 8];
      end
   end

   assign enc_data = (state == ST_RMW_WR) ? merged : mem_wdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         console_valid <= 1'b0;
         console_data  <= 8'h0;
         corr_count    <= 16'h0;
         uncorr_count  <= 16'h0;
      end else begin
         state         <= next_state;
         console_valid <= capture && is_console;
         if (capture && is_console) console_data <= mem_wdata[7:0];
         if (ecc_corrected)     corr_count   <= sat_inc(corr_count);
         if (ecc_uncorrectable) uncorr_count <= sat_inc(uncorr_count);
      end
   end

   // Request and scrub holding registers carry data only and need no reset.
   always_ff @(posedge clk) begin
      if (capture) begin
         req_idx   <= cur_idx;
         req_wdata <= mem_wdata;
         req_wstrb <= mem_wstrb;
      end
      if (state == ST_DEC) scrub_cw <= dec_cw;
   end

   always_ff @(posedge clk) begin
      if (ram_we) ram[ram_widx] <= ram_wcw;
      if (ram_re) ram_q <= ram[req_idx];
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (capture) begin
               if (is_console || !in_range)  next_state = ST_RESP;
               else if (mem_wstrb == 4'hF)   next_state = ST_RESP;
               else if (mem_wstrb == 4'h0)   next_state = ST_RD;
               else                          next_state = ST_RMW_RD;
            end
         end
         ST_RD:       next_state = ST_DEC;
         ST_DEC:      next_state = (single_err && SCRUB) ? ST_SCRUB_WR : ST_IDLE;
         ST_RMW_RD:   next_state = ST_RMW_WR;
         ST_RMW_WR:   next_state = ST_IDLE;
         ST_SCRUB_WR: next_state = ST_IDLE;
         ST_RESP:     next_state = ST_IDLE;
         default:     next_state = ST_IDLE;
      endcase
   end

   // RAM writes are gated by reset so an interrupted RMW or scrub never lands.
   always_comb begin
      mem_ready         = resp_state;
      mem_rdata         = 32'h0;
      ecc_corrected     = 1'b0;
      ecc_uncorrectable = 1'b0;
      ram_re            = 1'b0;
      ram_we            = 1'b0;
      ram_widx          = req_idx;
      ram_wcw           = enc_cw;
      case (state)
         ST_IDLE: begin
            if (capture && !is_console && in_range && mem_wstrb == 4'hF) begin
               ram_we   = !reset;
               ram_widx = cur_idx;
            end
         end
         ST_RD, ST_RMW_RD: ram_re = 1'b1;
         ST_DEC: begin
            mem_rdata         = dec_data;
            ecc_corrected     = single_err;
            ecc_uncorrectable = double_err;
         end
         ST_RMW_WR: begin
            ecc_corrected     = single_err;
            ecc_uncorrectable = double_err;
            ram_we            = !double_err && !reset;
         end
         ST_SCRUB_WR: begin
            ram_we  = !reset;
            ram_wcw = scrub_cw;
         end
         default: ;
      endcase
   end

endmodule
